// File: rtl/absmem_nw.sv
`default_nettype none
// ============================================================================
// Module  : absmem_nw
// Brief   : Abstract shared memory for vlg/ILA refinement checking. Each side
//           keeps an NW-entry write log over a shared read-only backing array.
// Revision: 1.0 - initial release
// ============================================================================
module absmem_nw #(
    parameter int AW  = 16,
    parameter int DW  = 8,
    parameter int TTS = 65536,
    parameter int NW  = 2,
    parameter int CW  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue,
    input  logic          compare,
    input  logic [AW-1:0] vlg_raddr,
    input  logic          vlg_ren,
    output logic [DW-1:0] vlg_rdata,
    input  logic [DW-1:0] vlg_r_rand_input,
    input  logic [AW-1:0] vlg_waddr,
    input  logic [DW-1:0] vlg_wdata,
    input  logic          vlg_wen,
    output logic [CW-1:0] vlg_cnt,
    output logic          vlg_ovf,
    input  logic [AW-1:0] ila_raddr,
    input  logic          ila_ren,
    output logic [DW-1:0] ila_rdata,
    input  logic [DW-1:0] ila_r_rand_input,
    input  logic [AW-1:0] ila_waddr,
    input  logic [DW-1:0] ila_wdata,
    input  logic          ila_wen,
    output logic [CW-1:0] ila_cnt,
    output logic          ila_ovf,
    output logic          equal
);
    localparam int c_IW = (NW > 1) ? $clog2(NW) : 1;

    // Backing array: never written here; symbolic in formal, preloaded in sim.
    logic [DW-1:0] mem [0:TTS-1];

    logic          r_armed;
    logic [AW-1:0] w_raddr [2];
    logic [AW-1:0] w_waddr [2];
    logic [DW-1:0] w_wdata [2];
    logic [DW-1:0] w_rand  [2];
    logic [1:0]    w_ren;
    logic [1:0]    w_wen;
    logic [NW-1:0] w_v     [2];
    logic [AW-1:0] w_a     [2][NW];
    logic [DW-1:0] w_d     [2][NW];
    logic [DW-1:0] w_rdata [2];
    logic [CW-1:0] w_cnt   [2];
    logic [1:0]    w_ovf;
    logic [1:0]    w_ok;

    assign w_raddr[0] = vlg_raddr;
    assign w_raddr[1] = ila_raddr;
    assign w_waddr[0] = vlg_waddr;
    assign w_waddr[1] = ila_waddr;
    assign w_wdata[0] = vlg_wdata;
    assign w_wdata[1] = ila_wdata;
    assign w_rand[0]  = vlg_r_rand_input;
    assign w_rand[1]  = ila_r_rand_input;
    assign w_ren      = {ila_ren, vlg_ren};
    assign w_wen      = {ila_wen, vlg_wen};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed <= 1'b0;
        end else if (issue) begin
            r_armed <= 1'b1;
        end
    end

    for (genvar s = 0; s < 2; s++) begin : g_side
        localparam int c_O = 1 - s;

        logic [NW-1:0]   r_v;
        logic [AW-1:0]   r_a [NW];
        logic [DW-1:0]   r_d [NW];
        logic [CW-1:0]   r_cnt;
        logic            r_ovf;
        logic            w_wen_real;
        logic            w_ren_real;
        logic            w_whit;
        logic            w_free;
        logic            w_rhit;
        logic [c_IW-1:0] w_whit_idx;
        logic [c_IW-1:0] w_free_idx;
        logic [DW-1:0]   w_rhit_d;
        logic [NW-1:0]   w_match;
        logic [NW-1:0]   w_ohit;
        logic [DW-1:0]   w_od [NW];

        assign w_wen_real = w_wen[s] & ~compare & r_armed;
        assign w_ren_real = w_ren[s] & ~compare & r_armed;

        always_comb begin
            w_whit     = 1'b0;
            w_whit_idx = '0;
            w_free     = 1'b0;
            w_free_idx = '0;
            w_rhit     = 1'b0;
            w_rhit_d   = '0;
            // Descending scan leaves the lowest free index selected.
            for (int i = NW - 1; i >= 0; i--) begin
                if (!r_v[i]) begin
                    w_free     = 1'b1;
                    w_free_idx = c_IW'(i);
                end
            end
            for (int i = 0; i < NW; i++) begin
                if (r_v[i] && (r_a[i] == w_waddr[s])) begin
                    w_whit     = 1'b1;
                    w_whit_idx = c_IW'(i);
                end
                if (r_v[i] && (r_a[i] == w_raddr[s])) begin
                    w_rhit   = 1'b1;
                    w_rhit_d = r_d[i];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_v   <= '0;
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else if (w_wen_real) begin
                if (w_whit) begin
                    r_d[w_whit_idx] <= w_wdata[s];
                end else if (w_free) begin
                    r_v[w_free_idx] <= 1'b1;
                    r_a[w_free_idx] <= w_waddr[s];
                    r_d[w_free_idx] <= w_wdata[s];
                    r_cnt           <= r_cnt + CW'(1);
                end else begin
                    r_ovf <= 1'b1;
                end
            end
        end

        // An entry is judged against the peer log first, memory otherwise.
        always_comb begin
            w_match = '1;
            for (int i = 0; i < NW; i++) begin
                w_ohit[i] = 1'b0;
                w_od[i]   = '0;
                for (int j = 0; j < NW; j++) begin
                    if (w_v[c_O][j] && (w_a[c_O][j] == r_a[i])) begin
                        w_ohit[i] = 1'b1;
                        w_od[i]   = w_d[c_O][j];
                    end
                end
                if (r_v[i]) begin
                    w_match[i] = w_ohit[i] ? (r_d[i] == w_od[i]) : (r_d[i] == mem[r_a[i]]);
                end
            end
        end

        assign w_v[s]     = r_v;
        assign w_a[s]     = r_a;
        assign w_d[s]     = r_d;
        assign w_cnt[s]   = r_cnt;
        assign w_ovf[s]   = r_ovf;
        assign w_ok[s]    = &w_match;
        assign w_rdata[s] = !w_ren_real ? w_rand[s] :
                            (w_rhit ? w_rhit_d : mem[w_raddr[s]]);
    end

    assign vlg_rdata = w_rdata[0];
    assign ila_rdata = w_rdata[1];
    assign vlg_cnt   = w_cnt[0];
    assign ila_cnt   = w_cnt[1];
    assign vlg_ovf   = w_ovf[0];
    assign ila_ovf   = w_ovf[1];
    assign equal     = compare & (&w_ok) & ~(|w_ovf);

endmodule
`default_nettype wire

// File: tb/tb_absmem_nw.sv
`default_nettype none
// ============================================================================
// Module  : tb_absmem_nw
// Brief   : Directed and randomized checks of absmem_nw against a log model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_absmem_nw;
    localparam int AW = 16, DW = 8, TTS = 65536, NW = 2, CW = 4;

    logic          clk = 1'b0;
    logic          rst, issue, compare;
    logic [AW-1:0] vlg_raddr, vlg_waddr, ila_raddr, ila_waddr;
    logic          vlg_ren, vlg_wen, ila_ren, ila_wen;
    logic [DW-1:0] vlg_rand, vlg_wdata, ila_rand, ila_wdata;
    logic [DW-1:0] vlg_rdata, ila_rdata;
    logic [CW-1:0] vlg_cnt, ila_cnt;
    logic          vlg_ovf, ila_ovf, equal;

    absmem_nw #(.AW(AW), .DW(DW), .TTS(TTS), .NW(NW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .issue(issue), .compare(compare),
        .vlg_raddr(vlg_raddr), .vlg_ren(vlg_ren), .vlg_rdata(vlg_rdata),
        .vlg_r_rand_input(vlg_rand), .vlg_waddr(vlg_waddr), .vlg_wdata(vlg_wdata),
        .vlg_wen(vlg_wen), .vlg_cnt(vlg_cnt), .vlg_ovf(vlg_ovf),
        .ila_raddr(ila_raddr), .ila_ren(ila_ren), .ila_rdata(ila_rdata),
        .ila_r_rand_input(ila_rand), .ila_waddr(ila_waddr), .ila_wdata(ila_wdata),
        .ila_wen(ila_wen), .ila_cnt(ila_cnt), .ila_ovf(ila_ovf),
        .equal(equal)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: memory image plus a map of logged writes keyed by {side, addr}.
    logic [7:0] mref [0:TTS-1];
    logic [7:0] md [int];
    int         m_cnt [2];
    bit         m_ovf [2];
    bit         m_armed;

    function automatic int key(int s, int a);
        return (s << 16) | a;
    endfunction

    task automatic mdl_write(int s, int a, logic [7:0] d);
        if (md.exists(key(s, a))) md[key(s, a)] = d;
        else if (m_cnt[s] < NW) begin
            md[key(s, a)] = d;
            m_cnt[s]++;
        end else m_ovf[s] = 1'b1;
    endtask

    function automatic logic [7:0] m_rdata(int s, logic ren, logic [15:0] a, logic [7:0] r);
        if (!(ren && !compare && m_armed)) return r;
        if (md.exists(key(s, a))) return md[key(s, a)];
        return mref[a];
    endfunction

    function automatic logic m_equal();
        logic ok;
        int   s, a, o;
        ok = compare && !m_ovf[0] && !m_ovf[1];
        foreach (md[k]) begin
            s = k >> 16;
            a = k & 16'hFFFF;
            o = key(1 - s, a);
            if (md.exists(o)) ok = ok && (md[k] == md[o]);
            else ok = ok && (md[k] == mref[a]);
        end
        return ok;
    endfunction

    // Advance one clock, applying the same cycle's inputs to the model.
    task automatic tick();
        if (rst) begin
            md.delete();
            m_cnt   = '{0, 0};
            m_ovf   = '{1'b0, 1'b0};
            m_armed = 1'b0;
        end else begin
            if (m_armed && !compare) begin
                if (vlg_wen) mdl_write(0, vlg_waddr, vlg_wdata);
                if (ila_wen) mdl_write(1, ila_waddr, ila_wdata);
            end
            if (issue) m_armed = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rst = 0; issue = 0; compare = 0;
        vlg_raddr = 0; vlg_ren = 0; vlg_rand = 0; vlg_waddr = 0; vlg_wdata = 0; vlg_wen = 0;
        ila_raddr = 0; ila_ren = 0; ila_rand = 0; ila_waddr = 0; ila_wdata = 0; ila_wen = 0;
    endtask

    task automatic poke(int a, logic [7:0] d);
        mref[a]     = d;
        dut.mem[a]  = d;
    endtask

    task automatic start();
        clear_inputs();
        rst = 1; tick();
        rst = 0; issue = 1; tick();
        issue = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1; tick(); tick();
        rst = 0;
        vlg_ren = 1; vlg_raddr = 16'd5; vlg_rand = 8'h5A;
        ila_ren = 1; ila_raddr = 16'd6; ila_rand = 8'hA5;
        #1;
        n_tests++;
        if (vlg_cnt !== 4'd0 || ila_cnt !== 4'd0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", vlg_cnt, ila_cnt);
        end
        n_tests++;
        if (vlg_ovf !== 1'b0 || ila_ovf !== 1'b0 || equal !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got ovf %b/%b equal %b want 0/0 0", vlg_ovf, ila_ovf, equal);
        end
        n_tests++;
        if (vlg_rdata !== 8'h5A || ila_rdata !== 8'hA5) begin
            n_fail++; $display("FAIL reset_rdata_unarmed: got %h/%h want 5a/a5", vlg_rdata, ila_rdata);
        end
    endtask

    task automatic test_read_through();
        start();
        poke(5, 8'h11);
        poke(300, 8'h77);
        vlg_ren = 1; vlg_raddr = 16'd5;
        ila_ren = 1; ila_raddr = 16'd300;
        #1;
        n_tests++;
        if (vlg_rdata !== 8'h11 || ila_rdata !== 8'h77) begin
            n_fail++; $display("FAIL read_through: got %h/%h want 11/77", vlg_rdata, ila_rdata);
        end
        vlg_ren = 0; vlg_rand = 8'hAB;
        #1;
        n_tests++;
        if (vlg_rdata !== 8'hAB) begin
            n_fail++; $display("FAIL read_rand: got %h want ab", vlg_rdata);
        end
    endtask

    task automatic test_overwrite();
        start();
        vlg_wen = 1; vlg_waddr = 16'd7; vlg_wdata = 8'h03; tick();
        vlg_wdata = 8'h09; vlg_ren = 1; vlg_raddr = 16'd7;
        #1;
        n_tests++;
        if (vlg_rdata !== 8'h03) begin
            n_fail++; $display("FAIL read_during_write: got %h want 03", vlg_rdata);
        end
        tick();
        vlg_wen = 0;
        #1;
        n_tests++;
        if (vlg_rdata !== 8'h09 || vlg_cnt !== 4'd1) begin
            n_fail++; $display("FAIL overwrite: got data %h cnt %0d want 09 1", vlg_rdata, vlg_cnt);
        end
    endtask

    task automatic test_matching();
        start();
        vlg_wen = 1; vlg_waddr = 16'd2; vlg_wdata = 8'h44;
        ila_wen = 1; ila_waddr = 16'd9; ila_wdata = 8'h55; tick();
        vlg_waddr = 16'd9; vlg_wdata = 8'h55;
        ila_waddr = 16'd2; ila_wdata = 8'h44; tick();
        vlg_wen = 0; ila_wen = 0; compare = 1;
        #1;
        n_tests++;
        if (equal !== 1'b1) begin
            n_fail++; $display("FAIL match_equal: got %b want 1", equal);
        end
        compare = 0; ila_wen = 1; ila_waddr = 16'd9; ila_wdata = 8'h56; tick();
        ila_wen = 0; compare = 1;
        #1;
        n_tests++;
        if (equal !== 1'b0 || ila_cnt !== 4'd2) begin
            n_fail++; $display("FAIL match_differs: got equal %b cnt %0d want 0 2", equal, ila_cnt);
        end
        compare = 0;
    endtask

    task automatic test_one_sided();
        start();
        poke(4, 8'h20);
        vlg_wen = 1; vlg_waddr = 16'd4; vlg_wdata = 8'h20; tick();
        vlg_wen = 0; compare = 1;
        #1;
        n_tests++;
        if (equal !== 1'b1) begin
            n_fail++; $display("FAIL one_sided_same: got %b want 1", equal);
        end
        compare = 0; vlg_wen = 1; vlg_wdata = 8'h21; tick();
        vlg_wen = 0; compare = 1;
        #1;
        n_tests++;
        if (equal !== 1'b0) begin
            n_fail++; $display("FAIL one_sided_diff: got %b want 0", equal);
        end
        compare = 0;
    endtask

    task automatic test_overflow();
        start();
        vlg_wen = 1; vlg_waddr = 16'd1; vlg_wdata = 8'h01; tick();
        vlg_waddr = 16'd2; vlg_wdata = 8'h02; tick();
        vlg_waddr = 16'd1; vlg_wdata = 8'h0F; tick();
        n_tests++;
        if (vlg_cnt !== 4'd2 || vlg_ovf !== 1'b0) begin
            n_fail++; $display("FAIL full_update: got cnt %0d ovf %b want 2 0", vlg_cnt, vlg_ovf);
        end
        vlg_waddr = 16'd3; vlg_wdata = 8'h03; tick();
        vlg_wen = 0; vlg_ren = 1; vlg_raddr = 16'd1;
        #1;
        n_tests++;
        if (vlg_cnt !== 4'd2 || vlg_ovf !== 1'b1 || ila_ovf !== 1'b0 || vlg_rdata !== 8'h0F) begin
            n_fail++; $display("FAIL overflow: got cnt %0d ovf %b/%b rd %h want 2 1/0 0f",
                               vlg_cnt, vlg_ovf, ila_ovf, vlg_rdata);
        end
        vlg_ren = 0; compare = 1;
        #1;
        n_tests++;
        if (equal !== 1'b0) begin
            n_fail++; $display("FAIL overflow_equal: got %b want 0", equal);
        end
        compare = 0; rst = 1; tick();
        rst = 0;
        n_tests++;
        if (vlg_cnt !== 4'd0 || vlg_ovf !== 1'b0) begin
            n_fail++; $display("FAIL overflow_reset: got cnt %0d ovf %b want 0 0", vlg_cnt, vlg_ovf);
        end
    endtask

    task automatic test_freeze_reset();
        start();
        compare = 1; vlg_wen = 1; vlg_waddr = 16'd6; vlg_wdata = 8'h66;
        vlg_ren = 1; vlg_raddr = 16'd6; vlg_rand = 8'hC3;
        #1;
        n_tests++;
        if (vlg_rdata !== 8'hC3) begin
            n_fail++; $display("FAIL freeze_read: got %h want c3", vlg_rdata);
        end
        tick();
        n_tests++;
        if (vlg_cnt !== 4'd0) begin
            n_fail++; $display("FAIL freeze_write: got cnt %0d want 0", vlg_cnt);
        end
        compare = 0; vlg_ren = 0; rst = 1; tick();
        rst = 0; tick();
        n_tests++;
        if (vlg_cnt !== 4'd0) begin
            n_fail++; $display("FAIL write_before_issue: got cnt %0d want 0", vlg_cnt);
        end
        issue = 1; tick();
        issue = 0; tick();
        n_tests++;
        if (vlg_cnt !== 4'd1) begin
            n_fail++; $display("FAIL write_after_issue: got cnt %0d want 1", vlg_cnt);
        end
        vlg_wen = 0; compare = 1; rst = 1; tick();
        rst = 0; compare = 0;
        #1;
        n_tests++;
        if (equal !== 1'b0 || vlg_cnt !== 4'd0 || ila_cnt !== 4'd0) begin
            n_fail++; $display("FAIL reset_in_compare: got equal %b cnt %0d/%0d want 0 0/0",
                               equal, vlg_cnt, ila_cnt);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_v, exp_i;
        logic       exp_e;
        start();
        for (int a = 0; a < 8; a++) poke(a, 8'($urandom_range(0, 3)));
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 63) == 0);
            issue     = ($urandom_range(0, 7) == 0);
            compare   = ($urandom_range(0, 5) == 0);
            vlg_ren   = 1'($urandom);
            ila_ren   = 1'($urandom);
            vlg_wen   = 1'($urandom);
            ila_wen   = 1'($urandom);
            vlg_raddr = 16'($urandom_range(0, 7));
            ila_raddr = 16'($urandom_range(0, 7));
            vlg_waddr = 16'($urandom_range(0, 7));
            ila_waddr = 16'($urandom_range(0, 7));
            vlg_wdata = 8'($urandom_range(0, 3));
            ila_wdata = 8'($urandom_range(0, 3));
            vlg_rand  = 8'($urandom);
            ila_rand  = 8'($urandom);
            #1;
            exp_v = m_rdata(0, vlg_ren, vlg_raddr, vlg_rand);
            exp_i = m_rdata(1, ila_ren, ila_raddr, ila_rand);
            exp_e = m_equal();
            n_tests++;
            if (vlg_rdata !== exp_v || ila_rdata !== exp_i) begin
                n_fail++; $display("FAIL rand_rdata[%0d]: got %h/%h want %h/%h", n, vlg_rdata, ila_rdata, exp_v, exp_i);
            end
            n_tests++;
            if (equal !== exp_e) begin
                n_fail++; $display("FAIL rand_equal[%0d]: got %b want %b", n, equal, exp_e);
            end
            tick();
            n_tests++;
            if (vlg_cnt !== CW'(m_cnt[0]) || ila_cnt !== CW'(m_cnt[1]) ||
                vlg_ovf !== m_ovf[0] || ila_ovf !== m_ovf[1]) begin
                n_fail++; $display("FAIL rand_state[%0d]: got cnt %0d/%0d ovf %b/%b want %0d/%0d %b/%b",
                                   n, vlg_cnt, ila_cnt, vlg_ovf, ila_ovf, m_cnt[0], m_cnt[1], m_ovf[0], m_ovf[1]);
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        m_cnt   = '{0, 0};
        m_ovf   = '{1'b0, 1'b0};
        m_armed = 1'b0;
        for (int i = 0; i < TTS; i++) begin
            mref[i]    = 8'($urandom);
            dut.mem[i] = mref[i];
        end
        test_reset();
        test_read_through();
        test_overwrite();
        test_matching();
        test_one_sided();
        test_overflow();
        test_freeze_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
